// File: rtl/add_tree_acc.sv
`default_nettype none
// ============================================================================
// Module   : add_tree_acc
// Brief    : Adder-tree back end: valid/last delay line, saturating dot-product
//            accumulator and valid/ready result register with stall generation.
// Revision : 1.0 - initial release
// ============================================================================
module add_tree_acc #(
    parameter int WORD_WDT = 16,
    parameter int TREE_LAT = 4,
    parameter int CNT_WDT  = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clk_en,
    input  logic                tree_in_val,
    input  logic                tree_in_last,
    input  logic [WORD_WDT-1:0] tree_out_word,
    output logic [WORD_WDT-1:0] acc_res,
    output logic                acc_res_val,
    input  logic                acc_res_rdy,
    output logic [CNT_WDT-1:0]  acc_cnt,
    output logic                acc_ovf,
    output logic                acc_stall
);

    localparam logic [WORD_WDT-1:0] c_pos_max = {1'b0, {(WORD_WDT-1){1'b1}}};
    localparam logic [WORD_WDT-1:0] c_neg_max = {1'b1, {(WORD_WDT-1){1'b0}}};
    localparam logic [CNT_WDT-1:0]  c_cnt_max = {CNT_WDT{1'b1}};

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_ACC  = 1'b1
    } state_t;

    state_t               r_state;
    logic [TREE_LAT-1:0]  r_dl_val;
    logic [TREE_LAT-1:0]  r_dl_last;
    logic [WORD_WDT-1:0]  r_acc;
    logic [CNT_WDT-1:0]   r_cnt;
    logic                 r_ovf;

    logic                 w_en_eff;
    logic                 w_d_val;
    logic                 w_d_last;
    logic [TREE_LAT-1:0]  w_dl_val_nxt;
    logic [TREE_LAT-1:0]  w_dl_last_nxt;
    logic [WORD_WDT:0]    w_sum;
    logic                 w_sat;
    logic [WORD_WDT-1:0]  w_acc_next;
    logic [CNT_WDT-1:0]   w_cnt_next;
    logic                 w_load;
    logic [WORD_WDT-1:0]  w_load_res;
    logic [CNT_WDT-1:0]   w_load_cnt;
    logic                 w_load_ovf;

    assign acc_stall = acc_res_val & ~acc_res_rdy;
    assign w_en_eff  = clk_en & ~acc_stall;
    assign w_d_val   = r_dl_val[TREE_LAT-1];
    assign w_d_last  = r_dl_last[TREE_LAT-1];

    generate
        if (TREE_LAT == 1) begin : g_dl_one
            assign w_dl_val_nxt  = tree_in_val;
            assign w_dl_last_nxt = tree_in_last;
        end else begin : g_dl_many
            assign w_dl_val_nxt  = {r_dl_val[TREE_LAT-2:0], tree_in_val};
            assign w_dl_last_nxt = {r_dl_last[TREE_LAT-2:0], tree_in_last};
        end
    endgenerate

    // One guard bit: overflow shows up as disagreement between the top two bits.
    assign w_sum      = {r_acc[WORD_WDT-1], r_acc} + {tree_out_word[WORD_WDT-1], tree_out_word};
    assign w_sat      = w_sum[WORD_WDT] ^ w_sum[WORD_WDT-1];
    assign w_acc_next = !w_sat ? w_sum[WORD_WDT-1:0] : (w_sum[WORD_WDT] ? c_neg_max : c_pos_max);
    assign w_cnt_next = (r_cnt == c_cnt_max) ? r_cnt : r_cnt + CNT_WDT'(1);

    always_comb begin
        w_load     = 1'b0;
        w_load_res = tree_out_word;
        w_load_cnt = CNT_WDT'(1);
        w_load_ovf = 1'b0;
        if (w_en_eff && w_d_val && w_d_last) begin
            w_load = 1'b1;
            if (r_state == S_ACC) begin
                w_load_res = w_acc_next;
                w_load_cnt = w_cnt_next;
                w_load_ovf = r_ovf | w_sat;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_dl_val    <= '0;
            r_dl_last   <= '0;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_ovf       <= 1'b0;
            acc_res     <= '0;
            acc_res_val <= 1'b0;
            acc_cnt     <= '0;
            acc_ovf     <= 1'b0;
        end else if (w_en_eff) begin
            r_dl_val  <= w_dl_val_nxt;
            r_dl_last <= w_dl_last_nxt;
            if (w_d_val) begin
                case (r_state)
                    S_IDLE: begin
                        r_acc <= tree_out_word;
                        r_cnt <= CNT_WDT'(1);
                        r_ovf <= 1'b0;
                        if (!w_d_last) r_state <= S_ACC;
                    end
                    S_ACC: begin
                        r_acc <= w_acc_next;
                        r_cnt <= w_cnt_next;
                        r_ovf <= r_ovf | w_sat;
                        if (w_d_last) r_state <= S_IDLE;
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
            // A new load overrides the accept so back-to-back results leave no bubble.
            if (w_load) begin
                acc_res     <= w_load_res;
                acc_cnt     <= w_load_cnt;
                acc_ovf     <= w_load_ovf;
                acc_res_val <= 1'b1;
            end else if (acc_res_rdy) begin
                acc_res_val <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_add_tree_acc.sv
`default_nettype none
// ============================================================================
// Module   : tb_add_tree_acc
// Brief    : Self-checking bench for add_tree_acc with a tree model and a
//            saturating dot-product reference scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_add_tree_acc;

    localparam int W = 16;
    localparam int L = 4;
    localparam int C = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         clk_en;
    logic         tree_in_val;
    logic         tree_in_last;
    logic [W-1:0] tree_out_word;
    logic [W-1:0] acc_res;
    logic         acc_res_val;
    logic         acc_res_rdy;
    logic [C-1:0] acc_cnt;
    logic         acc_ovf;
    logic         acc_stall;

    typedef struct packed {
        logic [W-1:0] res;
        logic [C-1:0] cnt;
        logic         ovf;
    } res_t;

    int     checks   = 0;
    int     failures = 0;
    int     n_acc    = 0;
    res_t   exp_q[$];
    res_t   last_acc;
    int     m_acc;
    int     m_n      = 0;
    logic   m_ovf;
    logic [W-1:0] tree_sum_in;
    logic [W-1:0] pipe [L];
    bit     tb_en    = 1'b0;
    bit     mon_on   = 1'b0;
    bit     done;
    logic   prev_hold = 1'b0;
    logic [W+C:0] prev_out;

    add_tree_acc #(.WORD_WDT(W), .TREE_LAT(L), .CNT_WDT(C)) dut (
        .clk           (clk),
        .rst           (rst),
        .clk_en        (clk_en),
        .tree_in_val   (tree_in_val),
        .tree_in_last  (tree_in_last),
        .tree_out_word (tree_out_word),
        .acc_res       (acc_res),
        .acc_res_val   (acc_res_val),
        .acc_res_rdy   (acc_res_rdy),
        .acc_cnt       (acc_cnt),
        .acc_ovf       (acc_ovf),
        .acc_stall     (acc_stall)
    );

    always #5 clk = ~clk;

    // Tree model: the sum appears L enabled cycles after its vector enters.
    assign tree_out_word = pipe[L-1];
    always @(negedge clk) tb_en = clk_en & ~acc_stall & ~rst;
    always @(posedge clk) begin
        if (tb_en) begin
            pipe[0] <= tree_sum_in;
            for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
        end
    end

    // Reference: plain integer sum clamped to the signed range after every chunk.
    function automatic void model_chunk(input logic [W-1:0] w, input logic l);
        res_t r;
        if (m_n == 0) begin
            m_acc = $signed(w);
            m_ovf = 1'b0;
        end else begin
            m_acc = m_acc + $signed(w);
            if (m_acc > 2**(W-1) - 1) begin m_acc = 2**(W-1) - 1; m_ovf = 1'b1; end
            else if (m_acc < -(2**(W-1))) begin m_acc = -(2**(W-1)); m_ovf = 1'b1; end
        end
        m_n++;
        if (l) begin
            r.res = m_acc[W-1:0];
            r.cnt = (m_n >= 2**C - 1) ? {C{1'b1}} : C'(m_n);
            r.ovf = m_ovf;
            exp_q.push_back(r);
            m_n = 0;
        end
    endfunction

    always @(negedge clk) begin
        if (mon_on && !rst) begin
            if (acc_res_rdy) begin
                checks++;
                if (acc_stall !== 1'b0) begin
                    failures++;
                    $display("FAIL stall_with_rdy: acc_stall=%b required 0", acc_stall);
                end
            end
            if (prev_hold) begin
                checks++;
                if ({acc_res, acc_cnt, acc_ovf} !== prev_out) begin
                    failures++;
                    $display("FAIL hold_stable: got %h required %h", {acc_res, acc_cnt, acc_ovf}, prev_out);
                end
            end
            if (clk_en && acc_res_val && acc_res_rdy) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_result: got res=%h cnt=%0d ovf=%b, none required",
                             acc_res, acc_cnt, acc_ovf);
                end else begin
                    res_t e;
                    e = exp_q.pop_front();
                    if ({acc_res, acc_cnt, acc_ovf} !== e) begin
                        failures++;
                        $display("FAIL result: got res=%h cnt=%0d ovf=%b required res=%h cnt=%0d ovf=%b",
                                 acc_res, acc_cnt, acc_ovf, e.res, e.cnt, e.ovf);
                    end
                end
                last_acc = {acc_res, acc_cnt, acc_ovf};
                n_acc++;
            end
            prev_hold = acc_res_val & ~acc_res_rdy;
            prev_out  = {acc_res, acc_cnt, acc_ovf};
        end else begin
            prev_hold = 1'b0;
        end
    end

    task automatic drive(input logic v, input logic l, input logic [W-1:0] w);
        tree_in_val  = v;
        tree_in_last = l;
        tree_sum_in  = v ? w : W'($urandom);
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (clk_en && !acc_stall) begin
                if (v) model_chunk(w, l);
                @(posedge clk); #1;
                tree_in_val  = 1'b0;
                tree_in_last = 1'b0;
                return;
            end
            @(posedge clk); #1;
        end
        checks++; failures++;
        $display("FAIL drive_timeout: input not taken in 200 cycles, required taken");
    endtask

    task automatic drain();
        acc_res_rdy = 1'b1;
        clk_en      = 1'b1;
        for (int t = 0; t < 100; t++) begin
            @(posedge clk); #1;
            if (exp_q.size() == 0 && !acc_res_val) break;
        end
        checks++;
        if (exp_q.size() != 0 || acc_res_val !== 1'b0) begin
            failures++;
            $display("FAIL drain: pending=%0d val=%b required 0 and 0", exp_q.size(), acc_res_val);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; clk_en = 1'b1; acc_res_rdy = 1'b1;
        tree_in_val = 1'b0; tree_in_last = 1'b0; tree_sum_in = '0;
        for (int i = 0; i < L; i++) pipe[i] = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({acc_res, acc_res_val, acc_cnt, acc_ovf, acc_stall} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: got %h required 0", {acc_res, acc_res_val, acc_cnt, acc_ovf, acc_stall});
        end
        rst = 1'b0;
        mon_on = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_single();
        int n;
        acc_res_rdy = 1'b1;
        drive(1'b1, 1'b1, 16'h0123);
        n = 1;
        while (!acc_res_val && n < 20) begin @(posedge clk); #1; n++; end
        checks++;
        if (n != L + 1) begin
            failures++;
            $display("FAIL single_latency: got %0d cycles required %0d", n, L + 1);
        end
        checks++;
        if ({acc_res, acc_cnt, acc_ovf} !== {16'h0123, 8'd1, 1'b0}) begin
            failures++;
            $display("FAIL single_value: got res=%h cnt=%0d ovf=%b required res=0123 cnt=1 ovf=0",
                     acc_res, acc_cnt, acc_ovf);
        end
        @(posedge clk); #1;
        checks++;
        if (acc_res_val !== 1'b0) begin
            failures++;
            $display("FAIL single_one_cycle: val=%b required 0", acc_res_val);
        end
        drain();
    endtask

    task automatic test_multi();
        int nval = 0;
        res_t cap = '0;
        drive(1'b1, 1'b0, 16'h0010);
        drive(1'b1, 1'b0, 16'h0020);
        drive(1'b1, 1'b1, 16'hFFF0);
        repeat (15) begin
            @(posedge clk); #1;
            if (acc_res_val) begin nval++; cap = {acc_res, acc_cnt, acc_ovf}; end
        end
        checks++;
        if (nval != 1) begin
            failures++;
            $display("FAIL multi_count: got %0d results required 1", nval);
        end
        checks++;
        if (cap !== {16'h0020, 8'd3, 1'b0}) begin
            failures++;
            $display("FAIL multi_value: got %h required %h", cap, {16'h0020, 8'd3, 1'b0});
        end
        drain();
    endtask

    task automatic test_sat();
        drive(1'b1, 1'b0, 16'h7000);
        drive(1'b1, 1'b1, 16'h7000);
        drain();
        checks++;
        if (last_acc !== {16'h7FFF, 8'd2, 1'b1}) begin
            failures++;
            $display("FAIL sat_pos: got %h required %h", last_acc, {16'h7FFF, 8'd2, 1'b1});
        end
        drive(1'b1, 1'b1, 16'h0001);
        drain();
        checks++;
        if (last_acc !== {16'h0001, 8'd1, 1'b0}) begin
            failures++;
            $display("FAIL sat_clear: got %h required %h", last_acc, {16'h0001, 8'd1, 1'b0});
        end
        drive(1'b1, 1'b0, 16'h8000);
        drive(1'b1, 1'b1, 16'hFFFF);
        drain();
        checks++;
        if (last_acc !== {16'h8000, 8'd2, 1'b1}) begin
            failures++;
            $display("FAIL sat_neg: got %h required %h", last_acc, {16'h8000, 8'd2, 1'b1});
        end
    endtask

    task automatic test_stall();
        int start;
        start = n_acc;
        acc_res_rdy = 1'b0;
        fork
            begin
                drive(1'b1, 1'b1, 16'h0100);
                drive(1'b1, 1'b0, 16'h0003);
                drive(1'b1, 1'b0, 16'h0004);
                drive(1'b1, 1'b1, 16'h0005);
                drive(1'b1, 1'b1, 16'hFF00);
            end
            begin
                int t;
                logic [W-1:0] hold;
                t = 0;
                while (!acc_res_val && t < 100) begin @(posedge clk); #1; t++; end
                hold = acc_res;
                repeat (3) begin
                    @(negedge clk);
                    checks++;
                    if (acc_stall !== 1'b1 || acc_res !== hold) begin
                        failures++;
                        $display("FAIL stall_window: stall=%b res=%h required stall=1 res=%h",
                                 acc_stall, acc_res, hold);
                    end
                end
                @(posedge clk); #1;
                acc_res_rdy = 1'b1;
            end
        join
        drain();
        checks++;
        if (n_acc - start != 3) begin
            failures++;
            $display("FAIL stall_results: got %0d results required 3", n_acc - start);
        end
    endtask

    task automatic test_back_to_back();
        int start;
        start = n_acc;
        acc_res_rdy = 1'b1;
        fork
            begin
                for (int i = 0; i < 8; i++) drive(1'b1, 1'b1, W'($urandom));
            end
            begin
                int t;
                t = 0;
                while (!acc_res_val && t < 100) begin @(posedge clk); #1; t++; end
                repeat (8) begin
                    @(negedge clk);
                    checks++;
                    if (acc_res_val !== 1'b1 || acc_stall !== 1'b0) begin
                        failures++;
                        $display("FAIL b2b_stream: val=%b stall=%b required val=1 stall=0",
                                 acc_res_val, acc_stall);
                    end
                end
            end
        join
        drain();
        checks++;
        if (n_acc - start != 8) begin
            failures++;
            $display("FAIL b2b_results: got %0d results required 8", n_acc - start);
        end
    endtask

    task automatic test_mid_reset();
        acc_res_rdy = 1'b1;
        drive(1'b1, 1'b0, 16'h0111);
        drive(1'b1, 1'b0, 16'h0222);
        rst = 1'b1;
        #1;
        checks++;
        if ({acc_res, acc_res_val, acc_cnt, acc_ovf, acc_stall} !== '0) begin
            failures++;
            $display("FAIL midreset_outputs: got %h required 0", {acc_res, acc_res_val, acc_cnt, acc_ovf, acc_stall});
        end
        exp_q.delete();
        m_n = 0;
        @(posedge clk); #1;
        rst = 1'b0;
        drive(1'b1, 1'b0, 16'h0001);
        drive(1'b1, 1'b0, 16'h0002);
        drive(1'b1, 1'b0, 16'h0003);
        drive(1'b1, 1'b1, 16'h0004);
        drain();
        checks++;
        if (last_acc !== {16'h000A, 8'd4, 1'b0}) begin
            failures++;
            $display("FAIL midreset_value: got %h required %h", last_acc, {16'h000A, 8'd4, 1'b0});
        end
    endtask

    task automatic test_random();
        done = 1'b0;
        fork
            begin
                for (int p = 0; p < 40; p++) begin
                    int len;
                    len = $urandom_range(1, 5);
                    for (int k = 0; k < len; k++) begin
                        logic [W-1:0] w;
                        if ($urandom_range(0, 1) == 0) w = W'($urandom);
                        else w = W'($urandom_range(0, 255) - 128);
                        if ($urandom_range(0, 3) == 0) drive(1'b0, 1'b0, '0);
                        drive(1'b1, k == len - 1, w);
                    end
                end
                for (int k = 0; k < 300; k++) drive(1'b1, k == 299, 16'h0001);
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk); #1;
                    acc_res_rdy = ($urandom_range(0, 3) != 0);
                    clk_en      = ($urandom_range(0, 7) != 0);
                end
            end
        join
        drain();
        checks++;
        if (last_acc !== {16'd300, 8'hFF, 1'b0}) begin
            failures++;
            $display("FAIL cnt_saturate: got %h required %h", last_acc, {16'd300, 8'hFF, 1'b0});
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_multi();
        test_sat();
        test_stall();
        test_back_to_back();
        test_mid_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
